// File: rtl/digit_renderer.sv
// Renders NUM_DIGITS scaled 8x8 decimal glyphs over the VGA pixel stream with a 3-cycle pipeline.
// Define DIGIT_RENDERER_HEX_EN to render codes 10..15 as A..F; otherwise those codes render blank.
`timescale 1ns/1ps
module digit_renderer #(
  parameter int         NUM_DIGITS = 4,
  parameter logic [9:0] X0         = 10'd200,
  parameter logic [9:0] Y0         = 10'd120,
  parameter int         SCALE_LOG2 = 2,
  parameter logic [2:0] FG_RGB     = 3'b100,
  parameter logic [2:0] BG_RGB     = 3'b000
) (
  input  logic       pix_clk,
  input  logic       reset_n,
  input  logic [9:0] x_in,
  input  logic [9:0] y_in,
  input  logic       valid_in,
  input  logic       hSync_in,
  input  logic       vSync_in,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_digit,
  output logic       hSync,
  output logic       vSync,
  output logic       R,
  output logic       G,
  output logic       B
);

  localparam int CELL = 8 << SCALE_LOG2;
  localparam logic [10:0] BOX_W = 11'(NUM_DIGITS * CELL);
  localparam logic [10:0] BOX_H = 11'(CELL);

  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [2:0] row);
    logic [63:0] g;
    case (code)
      4'd0:    g = 64'h3C666E7666663C00;
      4'd1:    g = 64'h183818181818_7E00;
      4'd2:    g = 64'h3C66060C30607E00;
      4'd3:    g = 64'h3C66061C06663C00;
      4'd4:    g = 64'h0C1C3C6C7E0C0C00;
      4'd5:    g = 64'h7E607C0606663C00;
      4'd6:    g = 64'h3C607C6666663C00;
      4'd7:    g = 64'h7E060C1830303000;
      4'd8:    g = 64'h3C66663C66663C00;
      4'd9:    g = 64'h3C66663E060C3800;
`ifdef DIGIT_RENDERER_HEX_EN
      4'd10:   g = 64'h183C66667E666600;
      4'd11:   g = 64'h7C66667C66667C00;
      4'd12:   g = 64'h3C66606060663C00;
      4'd13:   g = 64'h786C6666666C7800;
      4'd14:   g = 64'h7E60607860607E00;
      4'd15:   g = 64'h7E60607860606000;
`endif
      default: g = 64'h0;
    endcase
    return g[(7 - int'(row)) * 8 +: 8];
  endfunction

  // Stage 1 registers: box test and glyph coordinates
  logic       in_box1_q, in_box1_d;
  logic [2:0] cell1_q, cell1_d;
  logic [2:0] col1_q, col1_d;
  logic [2:0] row1_q, row1_d;
  logic       valid1_q;
  // Stage 2 registers: font ROM output
  logic [7:0] glyph2_q, glyph2_d;
  logic [2:0] col2_q;
  logic       in_box2_q;
  logic       valid2_q;
  // Stage 3 registers: colour
  logic [2:0] rgb3_q, rgb3_d;
  logic [2:0] hs_q, vs_dly_q;

  logic [3:0] shadow_q [0:7];
  logic [3:0] live_q   [0:7];
  logic       vs_q;
  logic       commit;
  logic       wr_ok;

  logic [9:0] dx, dy;
  logic       lit;

  always_comb begin
    dx        = x_in - X0;
    dy        = y_in - Y0;
    // dx/dy cannot wrap once x_in >= X0 and y_in >= Y0 hold, so the upper bounds compare offsets
    in_box1_d = (x_in >= X0) && ({1'b0, dx} < BOX_W) && (y_in >= Y0) && ({1'b0, dy} < BOX_H);
    cell1_d   = 3'(dx >> (3 + SCALE_LOG2));
    col1_d    = 3'(dx >> SCALE_LOG2);
    row1_d    = 3'(dy >> SCALE_LOG2);
  end

  always_comb begin
    glyph2_d = font_row(live_q[cell1_q], row1_q);
  end

  always_comb begin
    lit    = in_box2_q & glyph2_q[3'd7 - col2_q];
    rgb3_d = !valid2_q ? 3'b000 : (lit ? FG_RGB : BG_RGB);
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      in_box1_q <= 1'b0;
      cell1_q   <= '0;
      col1_q    <= '0;
      row1_q    <= '0;
      valid1_q  <= 1'b0;
      glyph2_q  <= '0;
      col2_q    <= '0;
      in_box2_q <= 1'b0;
      valid2_q  <= 1'b0;
      rgb3_q    <= 3'b000;
      hs_q      <= 3'b111;
      vs_dly_q  <= 3'b111;
    end else begin
      in_box1_q <= in_box1_d;
      cell1_q   <= cell1_d;
      col1_q    <= col1_d;
      row1_q    <= row1_d;
      valid1_q  <= valid_in;
      glyph2_q  <= glyph2_d;
      col2_q    <= col1_q;
      in_box2_q <= in_box1_q;
      valid2_q  <= valid1_q;
      rgb3_q    <= rgb3_d;
      hs_q      <= {hs_q[1:0], hSync_in};
      vs_dly_q  <= {vs_dly_q[1:0], vSync_in};
    end
  end

  // Commit copies the pre-write shadow; a write on the commit cycle waits for the next frame
  assign commit = vs_q & ~vSync_in;
  assign wr_ok  = wr_en && (int'(wr_idx) < NUM_DIGITS);

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 4'd0;
        live_q[i]   <= 4'd0;
      end
      vs_q <= 1'b1;
    end else begin
      vs_q <= vSync_in;
      if (commit) begin
        for (int i = 0; i < 8; i++) begin
          live_q[i] <= shadow_q[i];
        end
      end
      if (wr_ok) begin
        shadow_q[wr_idx] <= wr_digit;
      end
    end
  end

  assign R     = rgb3_q[2];
  assign G     = rgb3_q[1];
  assign B     = rgb3_q[0];
  assign hSync = hs_q[2];
  assign vSync = vs_dly_q[2];

endmodule

// File: tb/tb_digit_renderer.sv
// Bench for digit_renderer: directed scenarios plus random traffic checked against a pixel-level model.
`timescale 1ns/1ps
module tb_digit_renderer;

  localparam int         NUM_DIGITS = 4;
  localparam int         BOX_X0     = 200;
  localparam int         BOX_Y0     = 120;
  localparam int         CELL_PX    = 32;
  localparam int         DOT_PX     = 4;
  localparam logic [2:0] FG         = 3'b100;
  localparam logic [2:0] BG         = 3'b000;
`ifdef DIGIT_RENDERER_HEX_EN
  localparam bit HEX = 1'b1;
`else
  localparam bit HEX = 1'b0;
`endif

  // clock / reset
  logic pix_clk = 1'b0;
  logic reset_n = 1'b0;
  always #20 pix_clk = ~pix_clk;

  logic [9:0] x_in;
  logic [9:0] y_in;
  logic       valid_in, hSync_in, vSync_in;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [3:0] wr_digit;
  logic       hSync, vSync, R, G, B;

  digit_renderer dut (
    .pix_clk (pix_clk),
    .reset_n (reset_n),
    .x_in    (x_in),
    .y_in    (y_in),
    .valid_in(valid_in),
    .hSync_in(hSync_in),
    .vSync_in(vSync_in),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_digit(wr_digit),
    .hSync   (hSync),
    .vSync   (vSync),
    .R       (R),
    .G       (G),
    .B       (B)
  );

  // reference model state
  logic [7:0] font_tb [0:15][0:7];
  logic [3:0] m_shadow [0:7];
  logic [3:0] m_live   [0:7];
  logic       m_vs_prev;
  int         s1_x, s1_y;
  logic       s1_v;
  logic [2:0] exp_q[$];
  logic [1:0] sync_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int hs_low_cnt, vs_low_cnt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] render(input int x, input int y, input logic v);
    int d, c, r;
    logic [3:0] code;
    logic [7:0] bits;
    if (!v) return 3'b000;
    if (x < BOX_X0 || x >= BOX_X0 + NUM_DIGITS * CELL_PX || y < BOX_Y0 || y >= BOX_Y0 + CELL_PX)
      return BG;
    d    = (x - BOX_X0) / CELL_PX;
    c    = ((x - BOX_X0) % CELL_PX) / DOT_PX;
    r    = (y - BOX_Y0) / DOT_PX;
    code = m_live[d];
    if (code >= 4'd10 && !HEX) return BG;
    bits = font_tb[code][r];
    return bits[7 - c] ? FG : BG;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 4'd0;
      m_live[i]   = 4'd0;
    end
    m_vs_prev = 1'b1;
    s1_x = 0; s1_y = 0; s1_v = 1'b0;
    exp_q.delete();
    exp_q.push_back(3'b000);
    sync_q.delete();
    sync_q.push_back(2'b11);
    sync_q.push_back(2'b11);
  endtask

  // one clock: update the model for the inputs being driven, then check the outputs after the edge
  task automatic tick();
    logic [2:0] e;
    logic [1:0] s;
    exp_q.push_back(render(s1_x, s1_y, s1_v));
    s1_x = int'(x_in); s1_y = int'(y_in); s1_v = valid_in;
    sync_q.push_back({hSync_in, vSync_in});
    if (m_vs_prev && !vSync_in)
      for (int i = 0; i < 8; i++) m_live[i] = m_shadow[i];
    if (wr_en && int'(wr_idx) < NUM_DIGITS) m_shadow[wr_idx] = wr_digit;
    m_vs_prev = vSync_in;
    @(posedge pix_clk);
    #1;
    e = exp_q.pop_front();
    chk("rgb_model", {5'd0, R, G, B}, {5'd0, e});
    s = sync_q.pop_front();
    chk("sync_model", {6'd0, hSync, vSync}, {6'd0, s});
    if (!hSync) hs_low_cnt++;
    if (!vSync) vs_low_cnt++;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic v, input logic [2:0] exp);
    x_in = 10'(x); y_in = 10'(y); valid_in = v;
    repeat (3) tick();
    chk(tag, {5'd0, R, G, B}, {5'd0, exp});
  endtask

  task automatic wr(input int idx, input int d);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_digit = 4'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frame_edge();
    vSync_in = 1'b0;
    tick();
    vSync_in = 1'b1;
    tick();
  endtask

  initial begin
    font_tb[0]  = '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00};
    font_tb[1]  = '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
    font_tb[2]  = '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00};
    font_tb[3]  = '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00};
    font_tb[4]  = '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00};
    font_tb[5]  = '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00};
    font_tb[6]  = '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00};
    font_tb[7]  = '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00};
    font_tb[8]  = '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00};
    font_tb[9]  = '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00};
    font_tb[10] = '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00};
    font_tb[11] = '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00};
    font_tb[12] = '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00};
    font_tb[13] = '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00};
    font_tb[14] = '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h7E, 8'h00};
    font_tb[15] = '{8'h7E, 8'h60, 8'h60, 8'h78, 8'h60, 8'h60, 8'h60, 8'h00};

    x_in = '0; y_in = '0; valid_in = 1'b0; hSync_in = 1'b1; vSync_in = 1'b1;
    wr_en = 1'b0; wr_idx = '0; wr_digit = '0;
    hs_low_cnt = 0; vs_low_cnt = 0;

    // power-on reset
    repeat (3) @(posedge pix_clk);
    #1;
    chk("reset_rgb", {5'd0, R, G, B}, 8'd0);
    chk("reset_sync", {6'd0, hSync, vSync}, 8'h03);
    @(negedge pix_clk);
    reset_n = 1'b1;
    model_reset();
    repeat (3) tick();

    probe("glyph0_after_reset", 208, 120, 1'b1, FG);

    // lit pixel and exact latency
    wr(0, 8);
    frame_edge();
    valid_in = 1'b0;
    repeat (3) tick();
    x_in = 10'd208; y_in = 10'd120; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    chk("latency_2cyc", {5'd0, R, G, B}, 8'd0);
    tick();
    chk("latency_3cyc", {5'd0, R, G, B}, {5'd0, FG});

    // unlit pixel and box edges
    probe("col0_unlit", 200, 120, 1'b1, BG);
    probe("left_of_box", 199, 120, 1'b1, BG);
    probe("box_end", 328, 120, 1'b1, BG);
    probe("blanking", 208, 120, 1'b0, 3'b000);
    probe("above_box", 208, 119, 1'b1, BG);

    // tear-free update of digit 1
    wr(1, 1);
    probe("tear_hold_a", 236, 124, 1'b1, FG);
    probe("tear_hold_b", 244, 120, 1'b1, FG);
    frame_edge();
    probe("tear_commit_a", 236, 124, 1'b1, BG);
    probe("tear_commit_b", 244, 120, 1'b1, FG);

    // write on the commit cycle lands only at the following edge
    wr_en = 1'b1; wr_idx = 3'd2; wr_digit = 4'd8; vSync_in = 1'b0;
    tick();
    wr_en = 1'b0; vSync_in = 1'b1;
    tick();
    probe("commit_write_deferred", 268, 132, 1'b1, FG);
    frame_edge();
    probe("commit_write_next", 268, 132, 1'b1, BG);

    // out-of-range index ignored
    wr(5, 9);
    frame_edge();
    probe("bad_idx_d0", 208, 120, 1'b1, FG);
    probe("bad_idx_d1", 236, 124, 1'b1, BG);

    // hex code 12 in digit 3
    wr(3, 12);
    frame_edge();
    probe("code12", 304, 120, 1'b1, HEX ? FG : BG);

    // sync width preserved through the delay
    hs_low_cnt = 0;
    hSync_in = 1'b0;
    repeat (96) tick();
    hSync_in = 1'b1;
    repeat (5) tick();
    chk("hsync_width", 8'(hs_low_cnt), 8'd96);
    vs_low_cnt = 0;
    vSync_in = 1'b0;
    repeat (96) tick();
    vSync_in = 1'b1;
    repeat (5) tick();
    chk("vsync_width", 8'(vs_low_cnt), 8'd96);

    // random traffic against the model
    repeat (600) begin
      x_in     = 10'($urandom_range(180, 350));
      y_in     = 10'($urandom_range(100, 170));
      valid_in = ($urandom_range(0, 3) != 0);
      wr_en    = ($urandom_range(0, 3) == 0);
      wr_idx   = 3'($urandom_range(0, 7));
      wr_digit = 4'($urandom_range(0, 15));
      hSync_in = ($urandom_range(0, 9) != 0);
      vSync_in = ($urandom_range(0, 24) != 0);
      tick();
    end
    wr_en = 1'b0; hSync_in = 1'b1; vSync_in = 1'b1;
    repeat (3) tick();

    // asynchronous reset mid-line
    x_in = 10'd208; y_in = 10'd120; valid_in = 1'b1; hSync_in = 1'b0;
    wr(0, 8);
    frame_edge();
    repeat (4) tick();
    chk("pre_reset_rgb", {5'd0, R, G, B}, {5'd0, FG});
    #4;
    reset_n = 1'b0;
    #1;
    chk("async_reset_rgb", {5'd0, R, G, B}, 8'd0);
    chk("async_reset_sync", {6'd0, hSync, vSync}, 8'h03);
    @(posedge pix_clk);
    @(posedge pix_clk);
    hSync_in = 1'b1;
    @(negedge pix_clk);
    reset_n = 1'b1;
    model_reset();
    probe("glyph0_post_reset_a", 208, 120, 1'b1, FG);
    probe("glyph0_post_reset_b", 236, 124, 1'b1, FG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_renderer.md
Name: digit_renderer

Overview:
- Pixel-stage consumer of the VGA timing generator's x/y/valid/hSync/vSync stream.
- Renders a row of NUM_DIGITS scaled 8x8 decimal glyphs at a fixed screen position and drives 1-bit R/G/B to the pins.
- Digit values are loaded through a simple write port into a shadow bank. The bank is committed to the live bank only at frame start, so updates never tear.
- Sits between the VGA driver and the top-level colour outputs.

Parameters:
- NUM_DIGITS, 4: number of glyph cells, 1..8; digit 0 is leftmost.
- X0, 10'd200: left edge of cell 0, in pixels.
- Y0, 10'd120: top edge of the glyph row, in lines.
- SCALE_LOG2, 2: glyph pixel replication factor, 2^SCALE_LOG2. Cell width/height CELL = 8 << SCALE_LOG2.
- FG_RGB, 3'b100: {R,G,B} for a lit glyph pixel.
- BG_RGB, 3'b000: {R,G,B} for active video not covered by a lit glyph pixel.

Ports:
- pix_clk  in  1  pixel clock, 25.175 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- x_in  in  10  current pixel column from the timing generator.
- y_in  in  10  current line from the timing generator.
- valid_in  in  1  active-video flag from the timing generator.
- hSync_in  in  1  horizontal sync, active low.
- vSync_in  in  1  vertical sync, active low.
- wr_en  in  1  digit write strobe.
- wr_idx  in  3  digit index to write.
- wr_digit  in  4  digit code.
- hSync  out  1  hSync_in delayed to align with RGB.
- vSync  out  1  vSync_in delayed to align with RGB.
- R, G, B  out  1 each  pixel colour.

Interface: one clock, pix_clk. reset_n is asynchronous and active-low.

Behaviour:
- Reset (reset_n=0, any time, including mid-line):
  - R=G=B=0; hSync=vSync=1.
  - All pipeline registers cleared; sync delay taps set to 1.
  - Shadow and live digit banks = 4'd0; vsync edge register = 1.
- Pipeline, fixed latency 3 cycles. Every input sample appears at the outputs exactly 3 pix_clk later; hSync/vSync pass through an identical 3-stage delay.
  - S1 (register):
    - dx = x_in - X0; dy = y_in - Y0, both 10-bit.
    - in_box = (x_in >= X0) & (x_in < X0 + NUM_DIGITS*CELL) & (y_in >= Y0) & (y_in < Y0 + CELL).
    - cell = dx >> (3+SCALE_LOG2).
    - col = (dx >> SCALE_LOG2) & 7; row = (dy >> SCALE_LOG2) & 7.
    - valid_in is carried forward.
  - S2 (register): code = live[cell]; glyph_row = FONT[code][row], 8-bit, registered ROM output.
  - S3 (register):
    - lit = in_box & glyph_row[7-col]; bit 7 is the leftmost column.
    - {R,G,B} = !valid ? 3'b000 : lit ? FG_RGB : BG_RGB.
- Font: the team's standard 8x8 digit table, codes 0..9.
  - Row 7 of every glyph = 8'h00.
  - Glyph 8 row 0 = 8'h3C; glyph 1 row 0 = 8'h18.
  - Codes 10..15: see Optional Feature.
- Write port:
  - On wr_en=1 with wr_idx < NUM_DIGITS: shadow[wr_idx] <= wr_digit.
  - wr_idx >= NUM_DIGITS: write ignored, no other effect.
  - Writes are accepted every cycle; there is no backpressure.
- Commit:
  - vs_q = registered vSync_in; commit = vs_q & ~vSync_in (falling edge).
  - On commit: live <= shadow, all digits at once.
  - If wr_en coincides with commit, live takes the pre-write shadow value. The new write lands in shadow and goes live at the next frame.
- Live digits never change between commits, so a full frame renders one consistent value set.
- X/Y outside the box, including wrap from H_END back to 0, simply give in_box=0. No special cases.

Optional Feature:
- Macro: DIGIT_RENDERER_HEX_EN.
- Defined: codes 10..15 render glyphs A..F from the extended table. Glyph A row 0 = 8'h18.
- Undefined: codes 10..15 render blank; glyph_row forced to 8'h00, so the cell shows BG_RGB only.
- Latency and the port list are identical in both builds.

Test Plan:
- Reset check:
  - Stimulus: drive reset_n=0 for 2 cycles mid-frame with valid_in=1.
  - Required: R,G,B=0 and hSync=vSync=1 immediately (asynchronous). After release with x_in=208, y_in=120, the cell shows glyph 0.
- Latency / lit pixel:
  - Stimulus: write idx0=8, pulse vSync_in 1->0. Then present x_in=208, y_in=120, valid_in=1. (col=2; glyph 8 row 0 = 8'h3C; bit 5 = 1.)
  - Required: RGB=3'b100 exactly 3 cycles later.
- Unlit pixel and edges, same setup as the previous scenario:
  - x_in=200 (col 0) -> BG 3'b000.
  - x_in=199 -> BG.
  - x_in=328 (box end with NUM_DIGITS=4, CELL=32) -> BG.
  - valid_in=0 -> 3'b000.
- Tear-free update:
  - Stimulus: with vSync_in held 1, write idx1=1.
  - Required: pixel x_in=236, y_in=120 (idx1, col 1, glyph 0 row 0) is unchanged while vSync_in stays 1.
  - After the vSync_in falling edge, it renders glyph 1 (x_in=244, col 3 of 8'h18 lit).
  - A write issued on the commit cycle appears only after the next edge.
- Invalid index and code:
  - wr_idx=5 is ignored; all live digits are unchanged after commit.
  - Code 12: blank cell without DIGIT_RENDERER_HEX_EN; glyph C with it.
- Sync alignment: a hSync_in low pulse of 96 cycles appears on hSync delayed by exactly 3 cycles, with the same width; same for vSync.
